// File: rtl/trace_plotter.sv
// Decimates integrator samples, maps x1/x2 to screen rows and streams framebuffer
// writes: erase the column ahead, then draw connected vertical segments per trace.
module trace_plotter #(
  parameter int VGA_WIDTH  = 640,
  parameter int X1_TOP     = 56,
  parameter int X2_TOP     = 296,
  parameter int DECIM      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [17:0] x1,
  input  logic [17:0] x2,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [1:0]  pix_color,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  column,
  output logic        busy,
  output logic        overflow
);

  // state   | meaning
  // IDLE    | waiting for a mapped sample; pops it into cur_y1/cur_y2
  // ERASE   | 256 erase beats in the column ahead (x1 band, then x2 band)
  // DRAW1   | trace-1 segment from prev_y1 to cur_y1 at the current column
  // DRAW2   | trace-2 segment from prev_y2 to cur_y2 at the current column
  // ADVANCE | last beat drained; step column and remember this sample
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW1, S_DRAW2, S_ADVANCE} state_t;

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [9:0]    COL_LAST  = 10'(VGA_WIDTH - 1);
  localparam logic [8:0]    X1_TOP_R  = 9'(X1_TOP);
  localparam logic [8:0]    X1_BOT_R  = 9'(X1_TOP + 127);
  localparam logic [8:0]    X2_TOP_R  = 9'(X2_TOP);

  logic sync_rst;
  assign sync_rst = reset | clear;

  logic [DW-1:0] dcnt;
  logic          keep;
  assign keep = sample_valid && (dcnt == '0);

  always_ff @(posedge CLOCK_50) begin
    if (sync_rst)
      dcnt <= '0;
    else if (sample_valid)
      dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DW'(1);
  end

  // Offset-binary top bits, inverted so positive x plots upward.
  logic [6:0] u1_hi, u2_hi, r1, r2;
  logic [8:0] y1_new, y2_new;
  logic       unused_lsbs;
  assign u1_hi  = x1[17:11] ^ 7'h40;
  assign u2_hi  = x2[17:11] ^ 7'h40;
  assign r1     = ~u1_hi;
  assign r2     = ~u2_hi;
  assign y1_new = X1_TOP_R + {2'b00, r1};
  assign y2_new = X2_TOP_R + {2'b00, r2};
  assign unused_lsbs = ^{x1[10:0], x2[10:0]};

  state_t state, state_d;
  logic [17:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcount;
  logic          fifo_empty, fifo_full, pop, push_ok;
  logic [17:0]   fifo_rd;

  assign fifo_empty = (fcount == '0);
  assign fifo_full  = (fcount == FIFO_FULL);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign push_ok    = keep && (!fifo_full || pop);
  assign fifo_rd    = fifo_mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= {y1_new, y2_new};
  end

  always_ff @(posedge CLOCK_50) begin
    if (sync_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcount   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fcount <= fcount + (AW + 1)'(1);
        2'b01:   fcount <= fcount - (AW + 1)'(1);
        default: fcount <= fcount;
      endcase
      if (keep && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  logic [8:0] cur_y1, cur_y2, prev_y1, prev_y2, row, left;
  logic [8:0] cur_y1_d, cur_y2_d, prev_y1_d, prev_y2_d, row_d, left_d;
  logic       prev_valid, prev_valid_d, pix_valid_d;
  logic [9:0] column_d, pix_x_d, erase_col;
  logic [8:0] pix_y_d, lo1, hi1, lo2, hi2;
  logic [1:0] pix_color_d;
  logic       slot_free;

  assign slot_free = !pix_valid || pix_ready;
  assign erase_col = (column == COL_LAST) ? 10'd0 : column + 10'd1;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    lo1 = cur_y1;
    hi1 = cur_y1;
    lo2 = cur_y2;
    hi2 = cur_y2;
    if (prev_valid) begin
      if (prev_y1 < cur_y1) lo1 = prev_y1; else hi1 = prev_y1;
      if (prev_y2 < cur_y2) lo2 = prev_y2; else hi2 = prev_y2;
    end
  end

  always_comb begin
    state_d      = state;
    cur_y1_d     = cur_y1;
    cur_y2_d     = cur_y2;
    prev_y1_d    = prev_y1;
    prev_y2_d    = prev_y2;
    prev_valid_d = prev_valid;
    column_d     = column;
    row_d        = row;
    left_d       = left;
    pix_x_d      = pix_x;
    pix_y_d      = pix_y;
    pix_color_d  = pix_color;
    pix_valid_d  = pix_valid;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          cur_y1_d = fifo_rd[17:9];
          cur_y2_d = fifo_rd[8:0];
          row_d    = X1_TOP_R;
          left_d   = 9'd255;
          state_d  = S_ERASE;
        end
      end
      S_ERASE: begin
        if (slot_free) begin
          pix_valid_d = 1'b1;
          pix_x_d     = erase_col;
          pix_y_d     = row;
          pix_color_d = 2'b00;
          if (left == '0) begin
            state_d = S_DRAW1;
            row_d   = lo1;
            left_d  = hi1 - lo1;
          end else begin
            left_d = left - 9'd1;
            row_d  = (row == X1_BOT_R) ? X2_TOP_R : row + 9'd1;
          end
        end
      end
      S_DRAW1, S_DRAW2: begin
        if (slot_free) begin
          pix_valid_d = 1'b1;
          pix_x_d     = column;
          pix_y_d     = row;
          pix_color_d = (state == S_DRAW1) ? 2'b01 : 2'b10;
          if (left == '0) begin
            state_d = (state == S_DRAW1) ? S_DRAW2 : S_ADVANCE;
            row_d   = lo2;
            left_d  = hi2 - lo2;
          end else begin
            left_d = left - 9'd1;
            row_d  = row + 9'd1;
          end
        end
      end
      S_ADVANCE: begin
        // Wait for the final draw beat to be taken before moving on.
        if (slot_free) begin
          pix_valid_d = 1'b0;
          prev_y1_d   = cur_y1;
          prev_y2_d   = cur_y2;
          if (column == COL_LAST) begin
            column_d     = 10'd0;
            prev_valid_d = 1'b0;
          end else begin
            column_d     = column + 10'd1;
            prev_valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (sync_rst) begin
      state      <= S_IDLE;
      cur_y1     <= '0;
      cur_y2     <= '0;
      prev_y1    <= '0;
      prev_y2    <= '0;
      prev_valid <= 1'b0;
      column     <= '0;
      row        <= '0;
      left       <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= 2'b00;
      pix_valid  <= 1'b0;
    end else begin
      state      <= state_d;
      cur_y1     <= cur_y1_d;
      cur_y2     <= cur_y2_d;
      prev_y1    <= prev_y1_d;
      prev_y2    <= prev_y2_d;
      prev_valid <= prev_valid_d;
      column     <= column_d;
      row        <= row_d;
      left       <= left_d;
      pix_x      <= pix_x_d;
      pix_y      <= pix_y_d;
      pix_color  <= pix_color_d;
      pix_valid  <= pix_valid_d;
    end
  end

endmodule

// File: tb/tb_trace_plotter.sv
// Bench for trace_plotter: expected pixel stream built from the plotting rules,
// compared beat by beat, plus table vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_trace_plotter;
  localparam int W   = 24;
  localparam int D   = 3;
  localparam int X1T = 56;
  localparam int X2T = 296;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic [17:0] x1 = '0;
  logic [17:0] x2 = '0;
  logic [9:0]  pix_x, column;
  logic [8:0]  pix_y;
  logic [1:0]  pix_color;
  logic        pix_valid, busy, overflow;
  logic        pix_ready;
  logic        rand_ready = 1'b0;
  logic        ready_val = 1'b1;
  logic        rnd_bit = 1'b0;

  assign pix_ready = rand_ready ? rnd_bit : ready_val;

  trace_plotter #(.VGA_WIDTH(W), .X1_TOP(X1T), .X2_TOP(X2T), .DECIM(D), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .clear(clear), .sample_valid(sample_valid),
    .x1(x1), .x2(x2), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .column(column), .busy(busy),
    .overflow(overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) rnd_bit <= 1'($urandom_range(0, 1));

  typedef struct { logic [9:0] x; logic [8:0] y; logic [1:0] c; } beat_t;
  typedef struct { logic [17:0] x1; logic [17:0] x2; int y1; int y2; } vec_t;

  beat_t exp_q[$];
  beat_t st, mon_e;
  bit    stall_prev = 0;
  int    errors = 0, checks = 0;
  int    m_col = 0, m_py1 = 0, m_py2 = 0, m_dcnt = 0;
  bit    m_pv = 0;
  int    beat_total = 0, beat_formula = 0;
  int    d1_cnt, d1_first, d1_last, d1_x, d2_cnt, d2_first, er_x;
  bit    er_seen;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int map_row(input logic [17:0] x);
    int s;
    s = $signed(x);
    return 63 - (s >>> 11);
  endfunction

  task automatic model_add(input logic [17:0] a, input logic [17:0] b);
    int y1, y2, e, lo, hi;
    y1 = X1T + map_row(a);
    y2 = X2T + map_row(b);
    e = (m_col + 1 == W) ? 0 : m_col + 1;
    for (int r = 0; r < 128; r++) exp_q.push_back('{10'(e), 9'(X1T + r), 2'd0});
    for (int r = 0; r < 128; r++) exp_q.push_back('{10'(e), 9'(X2T + r), 2'd0});
    lo = (m_pv && m_py1 < y1) ? m_py1 : y1;
    hi = (m_pv && m_py1 > y1) ? m_py1 : y1;
    for (int r = lo; r <= hi; r++) exp_q.push_back('{10'(m_col), 9'(r), 2'd1});
    lo = (m_pv && m_py2 < y2) ? m_py2 : y2;
    hi = (m_pv && m_py2 > y2) ? m_py2 : y2;
    for (int r = lo; r <= hi; r++) exp_q.push_back('{10'(m_col), 9'(r), 2'd2});
    beat_formula += 256 + 2
      + (m_pv ? ((y1 > m_py1) ? y1 - m_py1 : m_py1 - y1) : 0)
      + (m_pv ? ((y2 > m_py2) ? y2 - m_py2 : m_py2 - y2) : 0);
    m_py1 = y1;
    m_py2 = y2;
    if (m_col == W - 1) begin
      m_col = 0;
      m_pv  = 0;
    end else begin
      m_col++;
      m_pv = 1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || pix_valid) && n < 6000) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy || pix_valid) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic pulse(input logic [17:0] a, input logic [17:0] b, input bit draw);
    bit kept;
    kept = (m_dcnt == 0);
    x1 = a;
    x2 = b;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    if (kept && draw) model_add(a, b);
    m_dcnt = (m_dcnt + 1) % D;
  endtask

  task automatic send_kept(input logic [17:0] a, input logic [17:0] b);
    while (m_dcnt != 0) pulse(18'($urandom), 18'($urandom), 1'b1);
    wait_idle("pace");
    pulse(a, b, 1'b1);
  endtask

  task automatic do_clear(input bit chk);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    if (chk) begin
      check("clr_pix_valid", pix_valid, 0);
      check("clr_column", column, 0);
      check("clr_busy", busy, 0);
      check("clr_overflow", overflow, 0);
    end
    exp_q.delete();
    m_col  = 0;
    m_pv   = 0;
    m_dcnt = 0;
  endtask

  task automatic reset_stats();
    d1_cnt = 0; d2_cnt = 0; d1_first = -1; d2_first = -1;
    d1_last = -1; d1_x = -1; er_x = -1; er_seen = 0;
  endtask

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (stall_prev) begin
          checks++;
          if (!pix_valid || pix_x != st.x || pix_y != st.y || pix_color != st.c) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b x=%0d y=%0d c=%0d, required v=1 x=%0d y=%0d c=%0d",
                     pix_valid, pix_x, pix_y, pix_color, st.x, st.y, st.c);
          end
        end
        if (pix_valid && pix_ready) begin
          beat_total++;
          if (pix_color == 2'd1) begin
            if (d1_cnt == 0) d1_first = int'(pix_y);
            d1_last = int'(pix_y);
            d1_x = int'(pix_x);
            d1_cnt++;
          end
          if (pix_color == 2'd2) begin
            if (d2_cnt == 0) d2_first = int'(pix_y);
            d2_cnt++;
          end
          if (pix_color == 2'd0 && !er_seen) begin
            er_x = int'(pix_x);
            er_seen = 1;
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: got x=%0d y=%0d c=%0d, required no beat", pix_x, pix_y, pix_color);
          end else begin
            mon_e = exp_q.pop_front();
            if (pix_x != mon_e.x || pix_y != mon_e.y || pix_color != mon_e.c) begin
              errors++;
              $display("FAIL beat: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                       pix_x, pix_y, pix_color, mon_e.x, mon_e.y, mon_e.c);
            end
          end
        end
        stall_prev = pix_valid && !pix_ready && !clear;
        st = '{pix_x, pix_y, pix_color};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[6];

  initial begin
    vt[0] = '{18'h00000, 18'h00000, 119, 359};
    vt[1] = '{18'h1FFFF, 18'h1FFFF,  56, 296};
    vt[2] = '{18'h20000, 18'h20000, 183, 423};
    vt[3] = '{18'h00800, 18'h3F800, 118, 360};
    vt[4] = '{18'h3F800, 18'h00800, 120, 358};
    vt[5] = '{18'h107FF, 18'h2F800,  87, 392};
    reset_stats();

    tick(3);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_color", pix_color, 0);
    check("rst_column", column, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 6; i++) begin
      do_clear(0);
      reset_stats();
      send_kept(vt[i].x1, vt[i].x2);
      wait_idle("vec_done");
      check("vec_y1", d1_first, vt[i].y1);
      check("vec_y2", d2_first, vt[i].y2);
      check("vec_single", d1_cnt, 1);
      check("vec_erase_col", er_x, 1);
      check("vec_column", column, 1);
      check("vec_busy", busy, 0);
      check("vec_drain", exp_q.size(), 0);
    end

    do_clear(0);
    repeat (6) send_kept(18'h00000, 18'h00000);
    wait_idle("seg_pre");
    reset_stats();
    send_kept(18'h1FFFF, 18'h00000);
    wait_idle("seg_done");
    check("seg_count", d1_cnt, 64);
    check("seg_first", d1_first, 56);
    check("seg_last", d1_last, 119);
    check("seg_col", d1_x, 6);
    check("seg_drain", exp_q.size(), 0);

    do_clear(0);
    beat_total = 0;
    beat_formula = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [17:0] a, b;
      tick($urandom_range(0, 3));
      a = 18'($urandom);
      b = 18'($urandom);
      if ($urandom_range(0, 3) == 0) a = 18'h1FFFF;
      if ($urandom_range(0, 3) == 0) b = 18'h20000;
      send_kept(a, b);
    end
    wait_idle("bp_done");
    rand_ready = 1'b0;
    check("bp_beat_total", beat_total, beat_formula);
    check("bp_drain", exp_q.size(), 0);
    check("bp_overflow", overflow, 0);

    do_clear(0);
    ready_val = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pulse(18'(i * 7001), 18'(i * 3203), i < 15);
      if (i == 12) check("ovf_before", overflow, 0);
      if (i == 15) check("ovf_set", overflow, 1);
    end
    check("ovf_busy", busy, 1);
    ready_val = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_sticky", overflow, 1);
    check("ovf_drain", exp_q.size(), 0);

    send_kept(18'h12345, 18'h2ABCD);
    tick(60);
    check("clr_mid_erase", (pix_valid && pix_color == 2'd0) ? 1 : 0, 1);
    do_clear(1);
    reset_stats();
    send_kept(18'h00000, 18'h00000);
    wait_idle("clr_after");
    check("clr_y1", d1_first, 119);
    check("clr_y2", d2_first, 359);
    check("clr_erase_col", er_x, 1);
    check("clr_column", column, 1);
    check("clr_drain", exp_q.size(), 0);

    do_clear(0);
    for (int i = 0; i <= W; i++) begin
      reset_stats();
      send_kept((i % 2) ? 18'h1FFFF : 18'h20000, (i % 2) ? 18'h20000 : 18'h1FFFF);
      wait_idle("wrap");
      if (i == W - 1) begin
        check("wrap_erase_col", er_x, 0);
        check("wrap_column", column, 0);
      end
      if (i == W) begin
        check("wrap_single1", d1_cnt, 1);
        check("wrap_single2", d2_cnt, 1);
        check("wrap_next_col", column, 1);
      end
    end
    check("wrap_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
